// File: rtl/counter8_pkg.sv
// Shared types and constants for the 8-bit interval timer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic       MODE_ONESHOT  = 1'b0;
    localparam logic       MODE_PERIODIC = 1'b1;
    localparam logic [7:0] TICKS_MAX     = 8'hFF;

endpackage

// File: rtl/counter8_timer_ctrl_if.sv
// Host/counter-pair side bundle of the interval timer controller.
// Latency: n/a (wiring only).
// Backpressure: none; requests are single-cycle pulses, HOLD is a level.
interface counter8_timer_ctrl_if;

    logic       START;
    logic       ABORT;
    logic       HOLD;
    logic       MODE;
    logic [7:0] PERIOD;
    logic       RCO;
    logic       nLOAD;
    logic [7:0] LD_VAL;
    logic       ENP;
    logic       ENT;
    logic       TC;
    logic [7:0] TICKS;
    logic       BUSY;
    logic       DONE;

    // Host plus counter pair: drives requests and ripple-carry, observes controls.
    modport master (
        output START, ABORT, HOLD, MODE, PERIOD, RCO,
        input  nLOAD, LD_VAL, ENP, ENT, TC, TICKS, BUSY, DONE
    );

    // The sequencing controller itself.
    modport slave (
        input  START, ABORT, HOLD, MODE, PERIOD, RCO,
        output nLOAD, LD_VAL, ENP, ENT, TC, TICKS, BUSY, DONE
    );

endinterface

// File: rtl/counter8_timer_ctrl.sv
// Sequences a cascaded pair of 4-bit loadable counters as a one-shot/periodic interval timer.
// Latency: START at edge k -> load pulse in cycle k..k+1 -> first TC in the N-th RUN cycle.
// Backpressure: HOLD freezes counting in RUN 1:1; START outside IDLE/DONE is dropped, ABORT always wins.
import counter8_pkg::*;

module counter8_timer_ctrl (
    input  logic                   CLK,
    input  logic                   CLR,
    counter8_timer_ctrl_if.slave   bus
);

    state_t     state;
    logic       mode_r;
    logic [7:0] ld_val_r;
    logic [7:0] ticks_r;

    logic       in_run;
    logic       count_en;
    logic       tc_w;
    logic       reload_w;

    // Count enables and terminal count decode straight from state, HOLD and RCO;
    // RCO is only meaningful while ENT is high, so it is gated by count_en.
    always_comb begin
        in_run   = (state == ST_RUN);
        count_en = in_run && !bus.HOLD;
        tc_w     = count_en && bus.RCO;
        reload_w = tc_w && (mode_r == MODE_PERIODIC);
    end

    assign bus.ENP    = count_en;
    assign bus.ENT    = count_en;
    assign bus.TC     = tc_w;
    // Load pulse in LOAD, and on terminal count in periodic mode (load overrides count).
    assign bus.nLOAD  = !((state == ST_LOAD) || reload_w);
    assign bus.LD_VAL = ld_val_r;
    assign bus.TICKS  = ticks_r;
    assign bus.BUSY   = (state == ST_LOAD) || in_run;
    assign bus.DONE   = (state == ST_DONE);

    // Controller state, latched mode, load value and completed-period count.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= ST_IDLE;
            mode_r   <= MODE_ONESHOT;
            ld_val_r <= 8'h00;
            ticks_r  <= 8'h00;
        end else if (bus.ABORT) begin
            // Abort drops back to IDLE but leaves TICKS readable.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.START) begin
                        state    <= ST_LOAD;
                        mode_r   <= bus.MODE;
                        // Counting up from 256-N reaches 255 after N cycles; PERIOD=0 wraps to 256.
                        ld_val_r <= 8'h00 - bus.PERIOD;
                        ticks_r  <= 8'h00;
                    end
                end
                ST_LOAD: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (tc_w) begin
                        if (ticks_r != TICKS_MAX) begin
                            ticks_r <= ticks_r + 8'd1;
                        end
                        if (mode_r == MODE_ONESHOT) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter8_timer_ctrl.sv
// Randomized and directed bench for counter8_timer_ctrl driving a behavioural counter pair.
// Latency: checks every cycle against a cycle-count reference model.
// Backpressure: exercises HOLD, ABORT and ignored START.
module tb_counter8_timer_ctrl;

    logic CLK;
    logic CLR;

    counter8_timer_ctrl_if bus ();

    counter8_timer_ctrl dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Two cascaded 4-bit loadable counters; they have no clear of their own.
    logic [3:0] q_lo = 4'd0;
    logic [3:0] q_hi = 4'd0;
    logic       rco_lo;
    assign rco_lo  = bus.ENT && (q_lo == 4'hF);
    assign bus.RCO = rco_lo && (q_hi == 4'hF);

    always @(posedge CLK) begin
        if (!bus.nLOAD) begin
            q_lo <= bus.LD_VAL[3:0];
            q_hi <= bus.LD_VAL[7:4];
        end else begin
            if (bus.ENP && bus.ENT) q_lo <= q_lo + 4'd1;
            if (bus.ENP && rco_lo)  q_hi <= q_hi + 4'd1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks cycles left in the current period rather than a counter value.
    bit m_loading, m_running, m_finished, m_periodic;
    int m_left, m_n, m_ticks, m_ld;
    bit obs_tc, obs_nload;

    task automatic model_reset();
        m_loading = 0; m_running = 0; m_finished = 0; m_periodic = 0;
        m_left = 0; m_n = 0; m_ticks = 0; m_ld = 0;
    endtask

    // One clock cycle: drive at negedge, compare mid-cycle, advance model, return at next negedge.
    task automatic step(input bit st, input bit ab, input bit hd, input bit md, input logic [7:0] per);
        bit e_en, e_tc, e_nload;
        bus.START = st; bus.ABORT = ab; bus.HOLD = hd; bus.MODE = md; bus.PERIOD = per;
        #1;
        e_en    = m_running && !hd;
        e_tc    = e_en && (m_left == 1);
        e_nload = !(m_loading || (e_tc && m_periodic));
        check("tc",     bus.TC,     e_tc);
        check("nload",  bus.nLOAD,  e_nload);
        check("enp",    bus.ENP,    e_en);
        check("ent",    bus.ENT,    e_en);
        check("busy",   bus.BUSY,   m_loading || m_running);
        check("done",   bus.DONE,   m_finished);
        check("ticks",  bus.TICKS,  m_ticks);
        check("ld_val", bus.LD_VAL, m_ld);
        obs_tc    = bus.TC;
        obs_nload = bus.nLOAD;
        if (ab) begin
            m_loading = 0; m_running = 0; m_finished = 0;
        end else if (!m_loading && !m_running && st) begin
            m_loading  = 1; m_finished = 0;
            m_n        = (per == 8'd0) ? 256 : int'(per);
            m_periodic = md;
            m_ticks    = 0;
            m_ld       = (256 - m_n) % 256;
        end else if (m_loading) begin
            m_loading = 0; m_running = 1; m_left = m_n;
        end else if (e_en) begin
            if (m_left == 1) begin
                if (m_ticks < 255) m_ticks++;
                if (m_periodic) m_left = m_n;
                else begin m_running = 0; m_finished = 1; end
            end else begin
                m_left--;
            end
        end
        @(negedge CLK);
        bus.START = 1'b0; bus.ABORT = 1'b0;
    endtask

    task automatic do_clr();
        bus.START = 0; bus.ABORT = 0; bus.HOLD = 0;
        CLR = 1'b1;
        #1;
        check("rst_nload",  bus.nLOAD,  1);
        check("rst_ld_val", bus.LD_VAL, 0);
        check("rst_enp",    bus.ENP,    0);
        check("rst_ent",    bus.ENT,    0);
        check("rst_tc",     bus.TC,     0);
        check("rst_ticks",  bus.TICKS,  0);
        check("rst_busy",   bus.BUSY,   0);
        check("rst_done",   bus.DONE,   0);
        model_reset();
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    // START then the LOAD cycle; the load pulse must appear exactly there.
    task automatic start_timer(input bit md, input logic [7:0] per);
        step(1, 0, 0, md, per);
        step(0, 0, 0, 0, 8'd0);
        check("load_pulse", obs_nload, 0);
    endtask

    // Counts RUN cycles up to and including the next TC.
    task automatic wait_tc(input string tag, input int max, input int exp_cycles);
        int cnt;
        cnt = 0;
        obs_tc = 0;
        while (!obs_tc && cnt < max) begin
            step(0, 0, 0, 0, 8'd0);
            cnt++;
        end
        if (!obs_tc) check({tag, "_timeout"}, cnt, exp_cycles + 1000);
        else         check(tag, cnt, exp_cycles);
    endtask

    initial begin
        bus.START = 0; bus.ABORT = 0; bus.HOLD = 0; bus.MODE = 0; bus.PERIOD = 8'd0;
        CLR = 1'b1;
        model_reset();
        @(negedge CLK);
        do_clr();

        // One-shot, PERIOD=5
        step(1, 0, 0, 0, 8'd5);
        check("os5_ld_val", bus.LD_VAL, 8'hFB);
        step(0, 0, 0, 0, 8'd0);
        check("os5_load", obs_nload, 0);
        wait_tc("os5_tc", 20, 5);
        check("os5_done",  bus.DONE,  1);
        check("os5_enp",   bus.ENP,   0);
        check("os5_ticks", bus.TICKS, 1);

        // Periodic, PERIOD=3, ten periods
        start_timer(1, 8'd3);
        for (int i = 0; i < 10; i++) begin
            wait_tc("per3_tc", 10, 3);
            check("per3_reload", obs_nload, 0);
        end
        check("per3_ticks", bus.TICKS, 10);
        step(0, 1, 0, 0, 8'd0);

        // Periodic, PERIOD=1: TC every cycle, TICKS saturates
        start_timer(1, 8'd1);
        check("p1_ld_val", bus.LD_VAL, 8'hFF);
        for (int i = 0; i < 5; i++) wait_tc("p1_tc", 2, 1);
        repeat (295) step(0, 0, 0, 0, 8'd0);
        check("p1_sat", bus.TICKS, 255);
        step(0, 1, 0, 0, 8'd0);

        // One-shot, PERIOD=0 means 256
        step(1, 0, 0, 0, 8'd0);
        check("p0_ld_val", bus.LD_VAL, 8'h00);
        step(0, 0, 0, 0, 8'd0);
        wait_tc("p0_tc", 300, 256);
        check("p0_done", bus.DONE, 1);

        // HOLD 4 cycles in a PERIOD=6 one-shot while the count sits at 0xFF
        start_timer(0, 8'd6);
        repeat (5) step(0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 8'd0);
            check("hold_no_tc", obs_tc, 0);
        end
        wait_tc("hold_tc", 5, 1);

        // START during RUN is ignored
        start_timer(0, 8'd4);
        step(1, 0, 0, 1, 8'd100);
        wait_tc("start_ign", 10, 3);
        check("start_ign_done", bus.DONE, 1);

        // ABORT with START in RUN: to IDLE, TICKS held
        start_timer(1, 8'd2);
        wait_tc("ab_tc", 5, 2);
        wait_tc("ab_tc", 5, 2);
        step(0, 0, 0, 0, 8'd0);
        step(1, 1, 0, 1, 8'd7);
        check("ab_enp",   bus.ENP,   0);
        check("ab_ent",   bus.ENT,   0);
        check("ab_busy",  bus.BUSY,  0);
        check("ab_done",  bus.DONE,  0);
        check("ab_ticks", bus.TICKS, 2);

        // CLR mid-RUN, then a fresh START reloads the pair
        start_timer(1, 8'd7);
        repeat (3) step(0, 0, 0, 0, 8'd0);
        do_clr();
        start_timer(0, 8'd3);
        wait_tc("clr_restart", 10, 3);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] per;
            per = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            if ($urandom_range(0, 399) == 0) do_clr();
            else step($urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0,
                      $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), per);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
